// File: rtl/demux4_buf_if.sv
// Producer/consumer bundle for demux4_buf: one tagged input stream and four
// independently handshaked output channels.
interface demux4_buf_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             in_bcast;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;
  logic [WIDTH-1:0] out_data2;
  logic [WIDTH-1:0] out_data3;

  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
  );
endinterface

// File: rtl/demux4_buf.sv
// 1-to-4 demultiplexer with a one-entry holding register per channel and an
// atomic broadcast mode; each channel drains over its own valid/ready pair.
module demux4_buf #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  demux4_buf_if.slave      bus,
  output logic [CNT_W-1:0] acc_cnt
);

  logic [3:0]       free;
  logic [3:0]       load;
  logic             accept;
  logic [3:0]       vld_p1;
  logic [WIDTH-1:0] data_p1 [4];

  // A full channel that drains this cycle can take a new word on the same edge.
  assign free        = ~vld_p1 | bus.out_ready;
  assign bus.in_ready = bus.in_bcast ? (&free) : free[bus.in_sel];
  assign accept      = bus.in_valid && bus.in_ready;

  always_comb begin
    load = 4'b0000;
    if (accept) begin
      if (bus.in_bcast) load = 4'b1111;
      else              load = 4'b0001 << bus.in_sel;
    end
  end

  // Stage p0 -> p1: holding registers; a load overrides a simultaneous drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 4'b0000;
      acc_cnt <= '0;
      for (int k = 0; k < 4; k++) data_p1[k] <= '0;
    end else begin
      vld_p1 <= load | (vld_p1 & ~bus.out_ready);
      if (accept) acc_cnt <= acc_cnt + CNT_W'(1);
      for (int k = 0; k < 4; k++) begin
        if (load[k]) data_p1[k] <= bus.in_data;
      end
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_data0 = data_p1[0];
  assign bus.out_data1 = data_p1[1];
  assign bus.out_data2 = data_p1[2];
  assign bus.out_data3 = data_p1[3];

endmodule

// File: tb/tb_demux4_buf.sv
// Scoreboard bench for demux4_buf: accepted words are queued per channel and
// checked as each consumer takes them; directed cases cover stalls and broadcast.
module tb_demux4_buf;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [CNT_W-1:0] acc_cnt;

  demux4_buf_if #(.WIDTH(WIDTH)) bus ();

  demux4_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .acc_cnt (acc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int               n_vec;
  int               n_err;
  logic [WIDTH-1:0] exp_q [4][$];
  logic [WIDTH-1:0] last_d [4];
  logic [CNT_W-1:0] cnt_m;
  logic             last_acc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] get_data(input int k);
    case (k)
      0:       return bus.out_data0;
      1:       return bus.out_data1;
      2:       return bus.out_data2;
      default: return bus.out_data3;
    endcase
  endfunction

  function automatic logic model_ready();
    logic [3:0] f;
    for (int k = 0; k < 4; k++) f[k] = (exp_q[k].size() == 0) || bus.out_ready[k];
    return bus.in_bcast ? (&f) : f[bus.in_sel];
  endfunction

  task automatic drive(input logic v, input logic [1:0] sel, input logic bc,
                       input logic [WIDTH-1:0] d, input logic [3:0] rdy);
    bus.in_valid  = v;
    bus.in_sel    = sel;
    bus.in_bcast  = bc;
    bus.in_data   = d;
    bus.out_ready = rdy;
  endtask

  // One clock: check outputs against the model before the edge, then update it.
  task automatic step();
    logic       acc;
    logic [3:0] ld;
    @(negedge clk);
    chk("in_ready", 64'(bus.in_ready), 64'(model_ready()));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("out_valid[%0d]", k), 64'(bus.out_valid[k]), 64'(exp_q[k].size() != 0));
      if (exp_q[k].size() != 0)
        chk($sformatf("out_data%0d", k), 64'(get_data(k)), 64'(exp_q[k][0]));
      else
        chk($sformatf("retain%0d", k), 64'(get_data(k)), 64'(last_d[k]));
    end
    chk("acc_cnt", 64'(acc_cnt), 64'(cnt_m));
    acc = bus.in_valid && model_ready();
    for (int k = 0; k < 4; k++)
      if (bus.out_ready[k] && exp_q[k].size() != 0) void'(exp_q[k].pop_front());
    if (acc) begin
      ld = bus.in_bcast ? 4'b1111 : (4'b0001 << bus.in_sel);
      for (int k = 0; k < 4; k++)
        if (ld[k]) begin
          exp_q[k].push_back(bus.in_data);
          last_d[k] = bus.in_data;
        end
      cnt_m = cnt_m + 1'b1;
    end
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      exp_q[k].delete();
      last_d[k] = '0;
    end
    cnt_m = '0;
  endtask

  initial begin
    logic [CNT_W-1:0] cnt_before;
    n_vec = 0;
    n_err = 0;
    last_acc = 1'b0;
    model_reset();
    drive(1'b0, 2'd0, 1'b0, '0, 4'b0000);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 64'(bus.out_valid), 64'h0);
    chk("reset_cnt", 64'(acc_cnt), 64'h0);
    chk("reset_data0", 64'(bus.out_data0), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Steering to channel 2, then a stalled second word.
    drive(1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 4'b0000);
    step();
    chk("steer_valid", 64'(bus.out_valid), 64'h4);
    chk("steer_data2", 64'(bus.out_data2), 64'hDEADBEEF);
    drive(1'b1, 2'd2, 1'b0, 32'h12345678, 4'b0000);
    #1;
    chk("steer_stall_rdy", 64'(bus.in_ready), 64'h0);
    step();
    chk("steer_stall_data", 64'(bus.out_data2), 64'hDEADBEEF);
    chk("steer_cnt", 64'(acc_cnt), 64'h1);
    drive(1'b0, 2'd0, 1'b0, '0, 4'b1111);
    step();

    // Back-to-back stream to channel 1 with its consumer always ready.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 2'd1, 1'b0, WIDTH'(i), 4'b0010);
      #1;
      chk("b2b_rdy", 64'(bus.in_ready), 64'h1);
      step();
      chk("b2b_data1", 64'(bus.out_data1), 64'(i));
      chk("b2b_valid1", 64'(bus.out_valid[1]), 64'h1);
    end
    drive(1'b0, 2'd0, 1'b0, '0, 4'b0010);
    step();

    // Broadcast blocked by a stalled channel 3, then released.
    drive(1'b1, 2'd3, 1'b0, 32'h33, 4'b0000);
    step();
    drive(1'b1, 2'd0, 1'b1, 32'h0000_00A5, 4'b0000);
    #1;
    chk("bc_blocked_rdy", 64'(bus.in_ready), 64'h0);
    step();
    chk("bc_blocked_valid", 64'(bus.out_valid), 64'h8);
    cnt_before = acc_cnt;
    bus.out_ready = 4'b1000;
    #1;
    chk("bc_rdy", 64'(bus.in_ready), 64'h1);
    step();
    chk("bc_valid", 64'(bus.out_valid), 64'hF);
    for (int k = 0; k < 4; k++) chk($sformatf("bc_data%0d", k), 64'(get_data(k)), 64'hA5);
    chk("bc_cnt", 64'(acc_cnt), 64'(cnt_before + 1'b1));

    // Independent stalls: drain channel 0 only.
    drive(1'b0, 2'd0, 1'b0, '0, 4'b0001);
    step();
    chk("stall_valid", 64'(bus.out_valid), 64'hE);
    bus.out_ready = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_hold_valid", 64'(bus.out_valid), 64'hE);
      chk("stall_hold_d1", 64'(bus.out_data1), 64'hA5);
      chk("stall_hold_d3", 64'(bus.out_data3), 64'hA5);
    end

    // Random traffic; an unaccepted word is held until it is taken.
    bus.in_valid = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (!bus.in_valid || last_acc) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_sel   = 2'($urandom);
        bus.in_bcast = ($urandom_range(0, 5) == 0);
        bus.in_data  = $urandom;
      end
      bus.out_ready = 4'($urandom);
      step();
    end
    drive(1'b0, 2'd0, 1'b0, '0, 4'b1111);
    repeat (2) step();

    // Asynchronous reset with a word pending and a full channel.
    drive(1'b1, 2'd1, 1'b0, 32'hCAFE0001, 4'b0000);
    step();
    drive(1'b1, 2'd0, 1'b0, 32'h77, 4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 64'(bus.out_valid), 64'h0);
    chk("async_cnt", 64'(acc_cnt), 64'h0);
    for (int k = 0; k < 4; k++) chk($sformatf("async_data%0d", k), 64'(get_data(k)), 64'h0);
    model_reset();
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Counter wrap at 2^CNT_W.
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1, 2'(i), 1'b0, WIDTH'(i + 100), 4'b1111);
      step();
      if (i == 15) chk("wrap_15", 64'(acc_cnt), 64'd15);
      if (i == 16) chk("wrap_16", 64'(acc_cnt), 64'd0);
      if (i == 17) chk("wrap_17", 64'(acc_cnt), 64'd1);
    end
    drive(1'b0, 2'd0, 1'b0, '0, 4'b1111);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/demux4_buf.md
Name: demux4_buf

Overview:
- 1-to-4 demultiplexer with per-channel output buffering; the distribution counterpart of the 4-input selector in the datapath.
- One input word, tagged with a 2-bit destination select, is steered into one of four one-entry holding registers. Each register drains independently over its own valid/ready handshake.
- A broadcast mode writes one word to all four channels atomically.
- Used wherever one producer feeds several datapath consumers that stall independently.

Parameters:
- WIDTH, 32, data word width in bits (must be ≥1).
- CNT_W, 16, width of the accepted-word counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer has a word
- in_ready  output  1  word is accepted this cycle when in_valid && in_ready
- in_data  input  WIDTH  input word
- in_sel  input  2  destination channel 0..3; ignored when in_bcast=1
- in_bcast  input  1  write word to all four channels
- out_valid  output  4  bit k: channel k holds a word
- out_ready  input  4  bit k: consumer k takes the word this cycle
- out_data0..out_data3  output  WIDTH each  channel k holding-register contents
- acc_cnt  output  CNT_W  count of accepted input transfers

Behaviour:
- Reset:
  - Asynchronous; rst_n low clears out_valid, all out_dataK and acc_cnt to 0 immediately, independent of clk.
  - In-flight words are discarded.
  - After release, the first accept is possible on the first rising edge with rst_n high.
- Per-channel free condition: free_k = !out_valid[k] || out_ready[k]. A full channel that is draining this cycle counts as free, giving 1 word/cycle/channel throughput.
- in_ready is combinational:
  - in_bcast=0: in_ready = free_{in_sel}.
  - in_bcast=1: in_ready = free_0 && free_1 && free_2 && free_3.
  - in_ready must not depend on in_valid.
  - The out_ready→in_ready combinational path is intentional.
- Accept (in_valid && in_ready) at a rising edge:
  - Targeted channel(s) load in_data and set out_valid=1.
  - Latency is 1 cycle: the word is visible on out_dataK/out_valid[k] in the cycle after the accepting edge.
  - Broadcast loads all four channels on the same edge; a partial broadcast is never performed.
- Drain: out_valid[k] && out_ready[k] at an edge, with no simultaneous load to k, clears out_valid[k].
- Data retention: out_dataK keeps its last value after draining; it changes only on a load or reset.
- Simultaneous drain and load on the same channel at one edge: the load wins. out_valid stays 1 and data is replaced by the new word; no bubble.
- Holding stability: while out_valid[k]=1 and out_ready[k]=0, out_dataK is stable.
- Not accepted (in_valid=1, in_ready=0): nothing changes. The producer must hold in_data, in_sel and in_bcast stable until accepted.
- in_valid=0: in_sel, in_bcast and in_data are don't-care and cause no state change.
- acc_cnt:
  - Increments by 1 per accepted transfer; a broadcast counts once.
  - Wraps from 2^CNT_W−1 to 0 with no flag.
- No internal state machine beyond the four valid bits and the counter. All storage is clocked on the rising edge of clk.

Test Plan:
- Reset: drive in_valid=1 and out_ready=4'b0000, then assert rst_n=0 mid-cycle. Required: out_valid=0, all out_dataK=0 and acc_cnt=0 immediately, with no clock edge needed.
- Steering: rst_n=1, out_ready=0; send in_sel=2, in_data=32'hDEADBEEF. Required: next cycle out_valid=4'b0100 and out_data2=32'hDEADBEEF. A second word to channel 2 sees in_ready=0 and is stalled with no state change. acc_cnt=1.
- Back-to-back: out_ready[1]=1 held; stream words 1,2,3,4 to channel 1 on consecutive cycles. Required: in_ready stays 1 throughout, out_data1 shows 1,2,3,4 on successive cycles, and out_valid[1] stays 1 with no bubble.
- Broadcast gating: channel 3 full with out_ready[3]=0; send in_bcast=1, data=32'h0000_00A5. Required: in_ready=0 and no channel is written. Raise out_ready[3]=1. Required: in_ready=1, all four channels hold 32'hA5 the next cycle, and acc_cnt increments by exactly 1.
- Independent stalls: fill all channels; drain only channel 0. Required: out_valid goes 4'b1111→4'b1110, and out_data1..3 stay unchanged for 10 cycles.
- Counter wrap: with CNT_W=4, accept 17 words. Required: acc_cnt reads 15 after the 15th accept, 0 after the 16th and 1 after the 17th.
